timeslot_multi: RTL

Parametrised successor to the single-piconet slot timer. One free-running microsecond slot counter is shared by N_CH independent piconet channels. Each channel keeps its own sync-derived slot offset, its own Bluetooth clock, its own slot and half-slot pulses, and a small enable/lock state machine. The block sits between the 1 us tick generator and the link controller / hop selection, and supports scatternet operation where one channel is master and the others track remote piconets.

---
 rtl/timeslot_multi.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/timeslot_multi.sv
// ---------------------------------------------------------------------------
// timeslot_multi
//   Multi-channel piconet slot timer. A single free-running microsecond slot
//   counter is shared by N_CH channels. Each channel keeps its own slot
//   offset (captured from sync-word correlation), its own Bluetooth clock,
//   its own slot / half-slot pulses and an IDLE/FREE/LOCKED state machine.
//
// Ports
//   clk_6M          system clock
//   rstz            asynchronous active-low reset
//   p_1us           single-cycle 1 us tick
//   ch_en           per-channel enable (level)
//   corre_sync_p    per-channel sync-word correlation pulse
//   pssyncCLK_p     per-channel page-scan clock sync pulse
//   clk_load_p      per-channel BTCLK load strobe
//   clk_load_val    per-channel BTCLK load value, channel i at [i*CLK_W +: CLK_W]
//   offset_clr_p    per-channel clear of slot offset and lock
//   counter_1us     shared slot counter
//   offcounter_1us  per-channel offset-corrected slot counter
//   slot_offset     per-channel captured slot offset
//   BTCLK           per-channel Bluetooth clock
//   tslot_p         per-channel slot-boundary pulse
//   half_tslot_p    per-channel half-slot pulse
//   sync_lock       per-channel LOCKED indication
// ---------------------------------------------------------------------------
module timeslot_multi #(
    parameter int N_CH     = 2,
    parameter int CLK_W    = 28,
    parameter int SLOT_US  = 625,
    parameter int SYNC_POS = 68,
    parameter int CNT_W    = 10
) (
    input  logic                    clk_6M,
    input  logic                    rstz,
    input  logic                    p_1us,
    input  logic [N_CH-1:0]         ch_en,
    input  logic [N_CH-1:0]         corre_sync_p,
    input  logic [N_CH-1:0]         pssyncCLK_p,
    input  logic [N_CH-1:0]         clk_load_p,
    input  logic [N_CH*CLK_W-1:0]   clk_load_val,
    input  logic [N_CH-1:0]         offset_clr_p,
    output logic [CNT_W-1:0]        counter_1us,
    output logic [N_CH*CNT_W-1:0]   offcounter_1us,
    output logic [N_CH*CNT_W-1:0]   slot_offset,
    output logic [N_CH*CLK_W-1:0]   BTCLK,
    output logic [N_CH-1:0]         tslot_p,
    output logic [N_CH-1:0]         half_tslot_p,
    output logic [N_CH-1:0]         sync_lock
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FREE   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SLOT_LEN  = CNT_W'(SLOT_US);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_US - 1);
    localparam logic [CNT_W-1:0] SLOT_HALF = CNT_W'(SLOT_US / 2);
    localparam logic [CNT_W-1:0] SYNC_AT   = CNT_W'(SYNC_POS);

    logic [CNT_W-1:0] counter_q, counter_d;
    state_t           state_q  [N_CH];
    state_t           state_d  [N_CH];
    logic [CNT_W-1:0] offset_q [N_CH];
    logic [CNT_W-1:0] offset_d [N_CH];
    logic [CLK_W-1:0] btclk_q  [N_CH];
    logic [CLK_W-1:0] btclk_d  [N_CH];

    logic [CNT_W:0]   off_sum  [N_CH];
    logic [CNT_W-1:0] offc     [N_CH];
    logic [CNT_W-1:0] capture  [N_CH];
    logic [N_CH-1:0]  active;
    // A channel reacts to sync/clear/pulse events only while enabled and out
    // of IDLE; dropping ch_en freezes offset and BTCLK on the way to IDLE.
    logic [N_CH-1:0]  live;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            for (int i = 0; i < N_CH; i++) state_q[i] <= ST_IDLE;
        end else begin
            for (int i = 0; i < N_CH; i++) state_q[i] <= state_d[i];
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            if (!ch_en[i]) begin
                state_d[i] = ST_IDLE;
            end else begin
                case (state_q[i])
                    ST_IDLE:   state_d[i] = ST_FREE;
                    // Clear beats a simultaneous correlation.
                    ST_FREE:   if (!offset_clr_p[i] && corre_sync_p[i]) state_d[i] = ST_LOCKED;
                    ST_LOCKED: if (offset_clr_p[i]) state_d[i] = ST_FREE;
                    default:   state_d[i] = ST_IDLE;
                endcase
            end
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            active[i]    = (state_q[i] != ST_IDLE);
            sync_lock[i] = (state_q[i] == ST_LOCKED);
            live[i]      = active[i] & ch_en[i];
        end
    end

    // ---------------- datapath: next values and pulses ----------------
    always_comb begin
        counter_d = counter_q;
        if (p_1us) counter_d = (counter_q == SLOT_LAST) ? '0 : counter_q + CNT_W'(1);

        for (int i = 0; i < N_CH; i++) begin
            // Both operands are below SLOT_US, so one subtract folds the sum.
            off_sum[i] = {1'b0, counter_q} + {1'b0, offset_q[i]};
            if (off_sum[i] >= {1'b0, SLOT_LEN}) off_sum[i] = off_sum[i] - {1'b0, SLOT_LEN};
            offc[i] = off_sum[i][CNT_W-1:0];

            // Offset that places offcounter at SYNC_POS in this very cycle.
            capture[i] = (counter_q <= SYNC_AT) ? (SYNC_AT - counter_q)
                                                : (SYNC_AT + SLOT_LEN - counter_q);

            tslot_p[i]      = p_1us & (offc[i] == SLOT_LAST) & active[i];
            half_tslot_p[i] = p_1us & (offc[i] == SLOT_HALF) & active[i];

            offset_d[i] = offset_q[i];
            if (live[i]) begin
                if (offset_clr_p[i])      offset_d[i] = '0;
                else if (corre_sync_p[i]) offset_d[i] = capture[i];
            end

            btclk_d[i] = btclk_q[i];
            if (clk_load_p[i]) begin
                btclk_d[i] = clk_load_val[i*CLK_W +: CLK_W];
            end else if (live[i]) begin
                if (pssyncCLK_p[i])                     btclk_d[i] = {btclk_q[i][CLK_W-1:2], 2'b11};
                else if (corre_sync_p[i])               btclk_d[i] = {btclk_q[i][CLK_W-1:2], 2'b00};
                else if (tslot_p[i] | half_tslot_p[i])  btclk_d[i] = btclk_q[i] + CLK_W'(1);
            end

            offcounter_1us[i*CNT_W +: CNT_W] = offc[i];
            slot_offset[i*CNT_W +: CNT_W]    = offset_q[i];
            BTCLK[i*CLK_W +: CLK_W]          = btclk_q[i];
        end
        counter_1us = counter_q;
    end

    // ---------------- datapath: registers ----------------
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            counter_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                offset_q[i] <= '0;
                btclk_q[i]  <= '0;
            end
        end else begin
            counter_q <= counter_d;
            for (int i = 0; i < N_CH; i++) begin
                offset_q[i] <= offset_d[i];
                btclk_q[i]  <= btclk_d[i];
            end
        end
    end

endmodule
